// File: rtl/cache_mem_ctrl_pkg.sv
// Shared definitions for the cache memory bus initiator.
//   state_e      : controller FSM states
//   DEF_*        : default widths / latency used as parameter defaults
//   RD_LAT_MAX   : largest supported memory read latency
//   WAIT_CNT_W   : width of the read-latency counter (covers 0..RD_LAT_MAX-1)
package cache_mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_RD_LAT = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int WAIT_CNT_W = $clog2(RD_LAT_MAX) + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEAT  = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RSP      = 3'd4
  } state_e;

endpackage

// File: rtl/cmc_burst_agen.sv
// Burst address generator: holds the current beat address and the number of
// beats still to go after the current one.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : capture load_addr / load_len (start of a burst)
//   step          : advance to the next beat (addr+1, remaining-1)
//   load_addr     : burst start address
//   load_len      : beats minus one
//   cur_addr      : address of the current beat
//   nxt_addr      : address of the following beat (modulo 2^ADDR_W)
//   last          : current beat is the final one of the burst
module cmc_burst_agen
  import cache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr;
      rem_d  = load_len;
    end else if (step) begin
      addr_d = nxt_addr;
      rem_d  = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign cur_addr = addr_q;
  // Natural rollover of the ADDR_W-bit sum gives the wrap to 0.
  assign nxt_addr = addr_q + ADDR_W'(1);
  assign last     = (rem_q == '0);

endmodule

// File: rtl/cache_mem_ctrl.sv
// Host-side initiator for the cache memory bus. Accepts single/burst
// read/write requests on a valid/ready host port, drives the memory
// rd_en/wr_en/addr/data_in pins and returns one response beat at a time.
// Optional feature macro: CACHE_MEM_CTRL_ADDR_WRAP_EN
//   defined   : bursts crossing the top address wrap to 0, req_err never set
//   undefined : a burst that would run past the top address is accepted and
//               then rejected with a one-cycle req_err pulse
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_write, req_addr, req_len    : request kind, start address, beats-1
//   req_err                         : one-cycle rejection pulse
//   wdata_valid/wdata_ready, wdata  : write beat handshake and data
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata, rsp_last             : read data (0 for write ack), final beat
//   mem_rd_en, mem_wr_en            : memory strobes (never both high)
//   mem_addr, mem_wdata, mem_rdata  : memory address / write data / read data
// All outputs are registered.
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_err,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic                  req_ready_q, req_ready_d;
  logic                  req_err_q, req_err_d;
  logic                  wdata_ready_q, wdata_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic                  agen_load, agen_step, agen_last;
  logic [ADDR_W-1:0]     agen_cur, agen_nxt;
  logic                  range_err;

  cmc_burst_agen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_agen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (agen_load),
    .step      (agen_step),
    .load_addr (req_addr),
    .load_len  (req_len),
    .cur_addr  (agen_cur),
    .nxt_addr  (agen_nxt),
    .last      (agen_last)
  );

`ifdef CACHE_MEM_CTRL_ADDR_WRAP_EN
  assign range_err = 1'b0;
`else
  // Extra bit catches a burst end address beyond 2^ADDR_W-1.
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic [SUM_W-1:0] end_addr;
  assign end_addr  = SUM_W'(req_addr) + SUM_W'(req_len);
  assign range_err = |(end_addr >> ADDR_W);
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    wait_cnt_d    = wait_cnt_q;
    req_ready_d   = req_ready_q;
    req_err_d     = 1'b0;
    wdata_ready_d = wdata_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_last_d    = rsp_last_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    agen_load     = 1'b0;
    agen_step     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          if (range_err) begin
            // Rejected request: stay idle and keep accepting.
            req_err_d = 1'b1;
          end else begin
            req_ready_d = 1'b0;
            agen_load   = 1'b1;
            write_d     = req_write;
            if (req_write) begin
              wdata_ready_d = 1'b1;
              state_d       = ST_WR_BEAT;
            end else begin
              // Strobe is registered, so it appears in the cycle after accept.
              mem_rd_en_d = 1'b1;
              mem_addr_d  = req_addr;
              state_d     = ST_RD_ISSUE;
            end
          end
        end
      end

      ST_WR_BEAT: begin
        if (wdata_valid && wdata_ready_q) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = agen_cur;
          mem_wdata_d = wdata;
          if (agen_last) begin
            wdata_ready_d = 1'b0;
            // Ack is prepared now but rsp_valid rises one cycle later,
            // after the final mem_wr_en cycle (see ST_RSP).
            rsp_valid_d   = 1'b0;
            rsp_rdata_d   = '0;
            rsp_last_d    = 1'b1;
            state_d       = ST_RSP;
          end else begin
            agen_step = 1'b1;
          end
        end
      end

      ST_RD_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (wait_cnt_q == WAIT_CNT_W'(RD_LAT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata;
          rsp_last_d  = agen_last;
          state_d     = ST_RSP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      ST_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_last_d  = 1'b0;
          if (write_q || agen_last) begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            agen_step   = 1'b1;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = agen_nxt;
            state_d     = ST_RD_ISSUE;
          end
        end else begin
          // Raises the deferred write ack; otherwise holds the read beat.
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      wait_cnt_q    <= '0;
      req_ready_q   <= 1'b0;
      req_err_q     <= 1'b0;
      wdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_last_q    <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      wait_cnt_q    <= wait_cnt_d;
      req_ready_q   <= req_ready_d;
      req_err_q     <= req_err_d;
      wdata_ready_q <= wdata_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_last_q    <= rsp_last_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign req_err     = req_err_q;
  assign wdata_ready = wdata_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_last    = rsp_last_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Testbench for cache_mem_ctrl: behavioural memory with RD_LAT read latency,
// an array reference model of memory contents and directed plus randomized
// transactions. Honours CACHE_MEM_CTRL_ADDR_WRAP_EN for the boundary rule.
module tb_cache_mem_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int LW     = 4;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready, req_write, req_err;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cache_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_err(req_err),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory plus a bench-side preload port.
  logic          bench_we;
  logic [AW-1:0] bench_addr;
  logic [DW-1:0] bench_data;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    else if (bench_we) mem[bench_addr] <= bench_data;
    if (mem_rd_en) rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Access log of every memory strobe.
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_addr_q[$];
  int overlap;
  initial overlap = 0;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
    end
    if (mem_rd_en) rd_addr_q.push_back(int'(mem_addr));
    if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
  end

  logic [DW-1:0] ref_mem [DEPTH];
  int total, bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    bench_we   = 1'b1;
    bench_addr = AW'(a);
    bench_data = d;
    tick();
    bench_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_req_err"},   32'(req_err), 0);
    check({tag, "_wready"},    32'(wdata_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check({tag, "_rsp_last"},  32'(rsp_last), 0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 0);
    check({tag, "_mem_addr"},  32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  // One complete transaction, checked against the reference model.
  // bp_beat/bp_cycles: hold rsp_ready low on that response beat.
  // ws_beat/ws_cycles: hold wdata_valid low before that write beat.
  task automatic run_req(input bit wr, input int addr, input int len,
                         input int bp_beat, input int bp_cycles,
                         input int ws_beat, input int ws_cycles,
                         input bit rand_data);
    logic [DW-1:0] wd [DEPTH];
    logic [DW-1:0] exp_d;
    int  k, rd_base, wr_base, a;
    bit  err;
    err = 1'b0;
`ifndef CACHE_MEM_CTRL_ADDR_WRAP_EN
    err = (addr + len) > (DEPTH - 1);
`endif
    for (int i = 0; i <= len; i++)
      wd[i] = rand_data ? DW'($urandom) : DW'((i + 1) * 17);
    rd_base = rd_addr_q.size();
    wr_base = wr_addr_q.size();

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    k = 0;
    while (!req_ready && k < 20) begin tick(); k++; end
    check("req_accept", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;

    if (err) begin
      check("err_pulse", 32'(req_err), 1);
      check("err_no_rd", 32'(mem_rd_en), 0);
      check("err_no_wr", 32'(mem_wr_en), 0);
      tick();
      check("err_one_cycle", 32'(req_err), 0);
      check("err_still_ready", 32'(req_ready), 1);
      repeat (3) tick();
      check("err_no_rsp", 32'(rsp_valid), 0);
      check("err_no_rd_log", 32'(rd_addr_q.size() - rd_base), 0);
      check("err_no_wr_log", 32'(wr_addr_q.size() - wr_base), 0);
      return;
    end
    check("no_err", 32'(req_err), 0);

    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        if (i == ws_beat) begin
          for (int c = 0; c < ws_cycles; c++) begin
            tick();
            check("wstall_no_wr", 32'(mem_wr_en), 0);
          end
        end
        wdata_valid = 1'b1;
        wdata       = wd[i];
        k = 0;
        while (!wdata_ready && k < 20) begin tick(); k++; end
        check("wdata_ready", 32'(wdata_ready), 1);
        tick();
        wdata_valid = 1'b0;
        a = (addr + i) % DEPTH;
        check("wr_en", 32'(mem_wr_en), 1);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_data", 32'(mem_wdata), 32'(wd[i]));
        check("wr_no_rd", 32'(mem_rd_en), 0);
      end
      check("ack_not_early", 32'(rsp_valid), 0);
      k = 0;
      while (!rsp_valid && k < 20) begin tick(); k++; end
      check("ack_latency", 32'(k), 1);
      if (bp_beat == 0) begin
        for (int c = 0; c < bp_cycles; c++) begin
          tick();
          check("ack_hold_valid", 32'(rsp_valid), 1);
          check("ack_hold_last", 32'(rsp_last), 1);
          check("ack_hold_no_wr", 32'(mem_wr_en), 0);
        end
      end
      check("ack_rdata", 32'(rsp_rdata), 0);
      check("ack_last", 32'(rsp_last), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int i = 0; i <= len; i++) ref_mem[(addr + i) % DEPTH] = wd[i];
      check("wr_log_count", 32'(wr_addr_q.size() - wr_base), 32'(len + 1));
      check("wr_rd_log_count", 32'(rd_addr_q.size() - rd_base), 0);
      for (int i = 0; i <= len && (wr_base + i) < wr_addr_q.size(); i++) begin
        check("wr_log_addr", 32'(wr_addr_q[wr_base + i]), 32'((addr + i) % DEPTH));
        check("wr_log_data", 32'(wr_data_q[wr_base + i]), 32'(wd[i]));
      end
    end else begin
      for (int i = 0; i <= len; i++) begin
        a     = (addr + i) % DEPTH;
        exp_d = ref_mem[a];
        check("rd_en", 32'(mem_rd_en), 1);
        check("rd_addr", 32'(mem_addr), 32'(a));
        k = 0;
        while (!rsp_valid && k < 20) begin tick(); k++; end
        check("rd_latency", 32'(k), 32'(1 + RD_LAT));
        if (i == bp_beat) begin
          for (int c = 0; c < bp_cycles; c++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_rdata", 32'(rsp_rdata), 32'(exp_d));
            check("bp_no_rd", 32'(mem_rd_en), 0);
          end
        end
        check("rd_rdata", 32'(rsp_rdata), 32'(exp_d));
        check("rd_last", 32'(rsp_last), 32'(i == len));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
      end
      check("rd_log_count", 32'(rd_addr_q.size() - rd_base), 32'(len + 1));
      check("rd_wr_log_count", 32'(wr_addr_q.size() - wr_base), 0);
      for (int i = 0; i <= len && (rd_base + i) < rd_addr_q.size(); i++)
        check("rd_log_addr", 32'(rd_addr_q[rd_base + i]), 32'((addr + i) % DEPTH));
    end
    check("idle_ready", 32'(req_ready), 1);
    check("idle_no_rsp", 32'(rsp_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, addr, len;
    bit wr;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
    bench_we = 1'b0; bench_addr = '0; bench_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_ready", 32'(req_ready), 1);
    check("post_reset_no_rsp", 32'(rsp_valid), 0);

    for (int i = 0; i < DEPTH; i++) preload(i, DW'($urandom));
    preload(3, 8'hA5);

    // Single read
    run_req(1'b0, 3, 0, -1, 0, -1, 0, 1'b0);
    // Write burst 0x11..0x44 at 2..5
    run_req(1'b1, 2, 3, -1, 0, -1, 0, 1'b0);
    // Read it back with 5 cycles of backpressure on the second beat
    run_req(1'b0, 2, 3, 1, 5, -1, 0, 1'b0);
    // Boundary crossing
    run_req(1'b0, 14, 3, -1, 0, -1, 0, 1'b0);
    // Write with a 4-cycle wdata stall before beat 1, then read back
    run_req(1'b1, 8, 2, 0, 2, 1, 4, 1'b1);
    run_req(1'b0, 8, 2, -1, 0, -1, 0, 1'b0);

    // Reset in the middle of a read burst
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_len = LW'(7);
    k = 0;
    while (!req_ready && k < 20) begin tick(); k++; end
    check("mid_accept", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    check("mid_beat0", 32'(rsp_rdata), 32'(ref_mem[0]));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("mid_beat1_issue", 32'(mem_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) tick();
    check_all_zero("mid_reset_hold");
    rst_n = 1'b1;
    tick();
    check("mid_release_ready", 32'(req_ready), 1);
    repeat (4) tick();
    check("mid_discard_rsp", 32'(rsp_valid), 0);
    check("mid_discard_rd", 32'(mem_rd_en), 0);
    run_req(1'b0, 5, 1, -1, 0, -1, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, 5));
      run_req(wr, addr, len,
              int'($urandom_range(0, len)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, len)), int'($urandom_range(0, 3)),
              1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    check("strobe_overlap", 32'(overlap), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
